// File: rtl/apb_pkg.sv
// Shared types and constants for the APB initiator and its helpers.
package apb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Register map of the peripheral this initiator usually talks to.
    localparam logic [ADDR_W-1:0] REG_TX      = 32'd0;
    localparam logic [ADDR_W-1:0] REG_RX      = 32'd4;
    localparam logic [ADDR_W-1:0] REG_CONFIG  = 32'd8;
    localparam logic [ADDR_W-1:0] REG_TIMEOUT = 32'd12;

    // Transfer sequencer states; RESP holds the response until it is taken.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_wait_counter.sv
// Counts ACCESS-phase wait cycles and flags when the wait budget is used up.
// A budget of 0 disables the timeout: expired never asserts.
module apb_wait_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    // Keep at least one bit so a disabled timeout still elaborates cleanly.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins over inc, and the count saturates instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (count_q == LIMIT);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB initiator: takes one command, runs SETUP/ACCESS on
// the bus, and holds the response until the requester accepts it.
//
// Handshake rule for both CMD and RSP channels: a beat transfers on the
// rising PCLK edge where VALID and READY are both 1; the source keeps VALID
// and its payload stable until that edge, and READY may depend on state only.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    // Command channel
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    // Response channel
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERROR,
    output logic              RSP_TIMEOUT,
    // APB initiator port
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    // Current sequencer state, for observation only
    output logic [1:0]        DBG_STATE
);

    apb_state_e        state_q;
    logic              cmd_ready_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_error_q;
    logic              rsp_timeout_q;

    logic wait_clear;
    logic wait_inc;
    logic wait_expired;

    // The counter is zeroed during SETUP so it reads 0 in the first ACCESS cycle.
    assign wait_clear = (state_q == ST_SETUP);
    assign wait_inc   = (state_q == ST_ACCESS) && !PREADY;

    apb_wait_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_counter (
        .clk     (PCLK),
        .rst     (PRESET),
        .clear   (wait_clear),
        .inc     (wait_inc),
        .expired (wait_expired)
    );

    // Transfer sequencer with all bus and response outputs registered.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        pwrite_q    <= CMD_WRITE;
                        paddr_q     <= CMD_ADDR;
                        pwdata_q    <= CMD_WDATA;
                        psel_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A ready slave beats a timeout landing on the same edge.
                    if (PREADY) begin
                        rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
                        rsp_error_q   <= PSLVERR;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= ST_RESP;
                    end else if (wait_expired) begin
                        rsp_rdata_q   <= '0;
                        rsp_error_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign CMD_READY   = cmd_ready_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_RDATA   = rsp_rdata_q;
    assign RSP_ERROR   = rsp_error_q;
    assign RSP_TIMEOUT = rsp_timeout_q;
    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign DBG_STATE   = state_q;

endmodule
